axis_switch_1xn_pkt: RTL
========================

AXIS_SWITCH_1XN_PKT -- requirements
Module: axis_switch_1xn_pkt

Interface
REQ-001 Parameters: DATAW, default 24, tdata width in bits, multiple of 8; NUM_M, default 4, master count, 2..16; DESTW, default 4, tdest width, at least clog2(NUM_M); BCAST, default 0, 0 = route by tdest, 1 = broadcast to all enabled masters.
REQ-002 Ports, in order:
- aclk, input, 1, sole clock.
- aresetn, input, 1, asynchronous active-low reset.
- m_en, input, NUM_M, per-master enable.
- s_axis_tdata, input, DATAW, slave data.
- s_axis_tvalid, input, 1, slave valid.
- s_axis_tready, output, 1, slave ready.
- s_axis_tuser, input, 1, slave user.
- s_axis_tlast, input, 1, end of packet.
- s_axis_tstrb, input, DATAW/8, byte strobe.
- s_axis_tkeep, input, DATAW/8, byte keep.
- s_axis_tid, input, 1, stream id.
- s_axis_tdest, input, DESTW, destination index.
- m_axis_tdata, output, NUM_M*DATAW, master i occupies slice [i*DATAW +: DATAW].
- m_axis_tvalid, output, NUM_M, per-master valid.
- m_axis_tready, input, NUM_M, per-master ready.
- m_axis_tuser, m_axis_tlast, m_axis_tid, output, NUM_M each, one bit per master.
- m_axis_tstrb, m_axis_tkeep, output, NUM_M*DATAW/8 each, per-master slices.
- m_axis_tdest, output, NUM_M*DESTW, per-master slices.
- busy, output, 1, high while a packet is locked.
- drop_cnt, output, 16, count of dropped packets.

Function
REQ-003 The block SHALL run a two-state FSM: IDLE (no packet locked) and PKT (a route mask is locked).
REQ-004 On a handshake in IDLE, the block SHALL compute a route mask. In BCAST=1 the mask is m_en. In BCAST=0 the mask is m_en AND onehot(s_axis_tdest). A tdest >= NUM_M gives mask 0.
REQ-005 If that first beat has tlast=0, the block SHALL lock the mask and enter PKT. If it has tlast=1, the block SHALL stay in IDLE (single-beat packet).
REQ-006 In PKT, the block SHALL use the locked mask for every beat. m_en changes SHALL take effect only at the next packet's first beat.
REQ-007 On a handshake with tlast=1 in PKT, the block SHALL return to IDLE. busy SHALL equal (state == PKT).
REQ-008 Each master SHALL have one output register stage. An accepted beat SHALL appear at m_axis_tvalid[i] on the next clock edge for every i in the mask; latency is 1 cycle.
REQ-009 The output register for master i is free when its valid is 0, or when m_axis_tvalid[i] and m_axis_tready[i] are both high in the same cycle.
REQ-010 s_axis_tready SHALL be high only when every output register selected by the current mask is free. The current mask is the locked mask in PKT, or the computed mask in IDLE. s_axis_tready SHALL be combinational from register state and m_axis_tready, never from s_axis_tvalid.
REQ-011 A broadcast beat SHALL be accepted once, only when all masked masters can take it. Masters outside the mask SHALL not be loaded.
REQ-012 All sideband fields (tuser, tlast, tstrb, tkeep, tid, tdest) SHALL be registered with tdata, unchanged.
REQ-013 m_axis_tvalid[i] SHALL hold until its handshake. The data on master i SHALL not change while valid is high and tready is low.
REQ-014 A packet whose mask is 0 SHALL be dropped. s_axis_tready SHALL be high for every beat, no master SHALL be loaded, and the FSM SHALL sequence normally.
REQ-015 drop_cnt SHALL increment by 1 on the cycle the dropped packet's tlast beat is accepted, and SHALL saturate at 0xFFFF.
REQ-016 Full throughput: with all masked readies held high, the block SHALL accept one beat per cycle with no bubbles.

Reset
REQ-017 While aresetn=0, the block SHALL asynchronously force: FSM to IDLE, locked mask 0, m_axis_tvalid all 0, s_axis_tready 0, busy 0, drop_cnt 0. All other m_axis data and sideband outputs SHALL be 0.
REQ-018 Release of aresetn SHALL be sampled synchronously. s_axis_tready SHALL not assert before the first rising aclk edge after release.
REQ-019 Reset during a packet SHALL discard the partial packet and all registered beats. No recovery or flush SHALL follow.

Verification
REQ-020 BCAST=0, NUM_M=4, m_en=4'b1111, 3-beat packet with tdest=2 -> beats appear only on master 2, one cycle later, in order, with tlast on beat 3; other valids stay 0.
REQ-021 BCAST=1, m_en=4'b0101, m_axis_tready[2]=0 for 5 cycles -> s_axis_tready=0 for those cycles; master 0 holds its beat; both masters receive identical data once tready[2]=1.
REQ-022 BCAST=0, tdest=7, or m_en[tdest]=0 -> 4-beat packet accepted at one beat per cycle; no master valid; drop_cnt goes 0 -> 1 on the tlast beat.
REQ-023 m_en changes from 4'b0001 to 4'b0010 mid-packet (tdest=0) -> remaining beats still go to master 0; the next packet with tdest=0 is dropped.
REQ-024 aresetn pulsed low during beat 2 of a packet with a master valid pending -> all valids 0 immediately; busy=0; drop_cnt=0; the next packet routes correctly.
REQ-025 Continuous 64-beat stream with all readies=1 -> 64 accepts in 64 consecutive cycles; drop_cnt saturation is forced by preload or long run and stays at 0xFFFF.

Source files
------------

// File: rtl/axis_switch_1xn_pkt.sv
// 1-to-N AXI-Stream packet switch: routes a packet by tdest (or broadcasts to enabled masters),
// locks the route for the whole packet, and drops packets whose route mask is empty.
module axis_switch_1xn_pkt #(
  parameter int DATAW = 24,
  parameter int NUM_M = 4,
  parameter int DESTW = 4,
  parameter int BCAST = 0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_M-1:0]           m_en,
  input  logic [DATAW-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  input  logic [DATAW/8-1:0]         s_axis_tstrb,
  input  logic [DATAW/8-1:0]         s_axis_tkeep,
  input  logic                       s_axis_tid,
  input  logic [DESTW-1:0]           s_axis_tdest,
  output logic [NUM_M*DATAW-1:0]     m_axis_tdata,
  output logic [NUM_M-1:0]           m_axis_tvalid,
  input  logic [NUM_M-1:0]           m_axis_tready,
  output logic [NUM_M-1:0]           m_axis_tuser,
  output logic [NUM_M-1:0]           m_axis_tlast,
  output logic [NUM_M-1:0]           m_axis_tid,
  output logic [NUM_M*DATAW/8-1:0]   m_axis_tstrb,
  output logic [NUM_M*DATAW/8-1:0]   m_axis_tkeep,
  output logic [NUM_M*DESTW-1:0]     m_axis_tdest,
  output logic                       busy,
  output logic [15:0]                drop_cnt
);

  localparam int KW = DATAW / 8;

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_M-1:0]     mask_q, mask_d;
  logic [NUM_M-1:0]     calc_mask, cur_mask, free, load;
  logic                 rdy_en_q;
  logic                 hs;
  logic [15:0]          drop_q;

  logic [NUM_M-1:0]       vld_q, user_q, last_q, id_q;
  logic [NUM_M*DATAW-1:0] data_q;
  logic [NUM_M*KW-1:0]    strb_q, keep_q;
  logic [NUM_M*DESTW-1:0] dest_q;

  function automatic logic [NUM_M-1:0] route_mask(input logic [NUM_M-1:0] en,
                                                  input logic [DESTW-1:0] dest);
    logic [NUM_M-1:0] m;
    m = '0;
    if (BCAST != 0) begin
      m = en;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (dest == DESTW'(i)) m[i] = en[i];
      end
    end
    return m;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign calc_mask = route_mask(m_en, s_axis_tdest);
  assign cur_mask  = (state_q == PKT) ? mask_q : calc_mask;
  assign free      = ~vld_q | m_axis_tready;

  // rdy_en_q keeps tready low until the first edge after reset release
  assign s_axis_tready = rdy_en_q & (&(free | ~cur_mask));
  assign hs            = s_axis_tvalid & s_axis_tready;
  assign load          = cur_mask & {NUM_M{hs}};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: if (hs && !s_axis_tlast) begin
        state_d = PKT;
        mask_d  = calc_mask;
      end
      PKT: if (hs && s_axis_tlast) begin
        state_d = IDLE;
        mask_d  = '0;
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == PKT);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (hs && s_axis_tlast && (cur_mask == '0)) drop_q <= sat_inc(drop_q);
    end
  end

  // One output register per master; a held beat only leaves on its own handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q  <= '0;
      user_q <= '0;
      last_q <= '0;
      id_q   <= '0;
      data_q <= '0;
      strb_q <= '0;
      keep_q <= '0;
      dest_q <= '0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (load[i]) begin
          vld_q[i]                  <= 1'b1;
          user_q[i]                 <= s_axis_tuser;
          last_q[i]                 <= s_axis_tlast;
          id_q[i]                   <= s_axis_tid;
          data_q[i*DATAW +: DATAW]  <= s_axis_tdata;
          strb_q[i*KW +: KW]        <= s_axis_tstrb;
          keep_q[i*KW +: KW]        <= s_axis_tkeep;
          dest_q[i*DESTW +: DESTW]  <= s_axis_tdest;
        end else if (m_axis_tready[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tvalid = vld_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tlast  = last_q;
  assign m_axis_tid    = id_q;
  assign m_axis_tstrb  = strb_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tdest  = dest_q;
  assign drop_cnt      = drop_q;

endmodule
